// File: rtl/reshaper_wr_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : reshaper_wr_buf                                                  |
// | Brief   : Elastic write buffer between the reshaper and the feature-map    |
// |           SRAM. Optional peak-occupancy port under RESHAPER_WBUF_HWM_EN.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module reshaper_wr_buf #(
  parameter int AW    = 16,
  parameter int DW    = 512,
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    init_pulse,
  input  logic [AW-1:0]           waddr,
  input  logic [DW-1:0]           wdata,
  input  logic                    wdata_vld,
  input  logic                    finish,
  output logic [AW-1:0]           mem_waddr,
  output logic [DW-1:0]           mem_wdata,
  output logic                    mem_wvld,
  input  logic                    mem_wrdy,
  output logic [CNTW-1:0]         wr_cnt,
  output logic                    ovf,
`ifdef RESHAPER_WBUF_HWM_EN
  output logic [$clog2(DEPTH):0]  hwm,
`endif
  output logic                    done
);

  localparam int            c_PW      = $clog2(DEPTH);
  localparam logic [CNTW-1:0] c_CNT_MAX = {CNTW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_PW:0]        r_wptr;
  logic [c_PW:0]        r_rptr;
  logic [CNTW-1:0]      r_wr_cnt;
  logic                 r_ovf;
  logic [AW+DW-1:0]     r_mem [DEPTH];

  logic                 w_empty;
  logic                 w_full;
  logic                 w_push_req;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_drop;
  logic [c_PW:0]        w_count;
  logic [c_PW:0]        w_count_nxt;
  logic [AW+DW-1:0]     w_head;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[c_PW] != r_rptr[c_PW]) &&
                       (r_wptr[c_PW-1:0] == r_rptr[c_PW-1:0]);
  assign w_count     = r_wptr - r_rptr;

  // init_pulse wins over any same-cycle push or pop.
  assign w_push_req  = wdata_vld && !init_pulse &&
                       ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign w_pop       = !w_empty && mem_wrdy && !init_pulse;
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop      = w_push_req && w_full && !w_pop;
  assign w_count_nxt = w_count + (c_PW+1)'(w_push) - (c_PW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[c_PW-1:0]] <= {waddr, wdata};
    end
  end

  assign w_head    = r_mem[r_rptr[c_PW-1:0]];
  assign mem_wvld  = !w_empty;
  assign mem_waddr = w_empty ? '0 : w_head[AW+DW-1:DW];
  assign mem_wdata = w_empty ? '0 : w_head[DW-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_wr_cnt <= '0;
      r_ovf    <= 1'b0;
    end else if (init_pulse) begin
      r_state  <= S_RUN;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_wr_cnt <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_pop && (r_wr_cnt != c_CNT_MAX)) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Completion is taken on the edge that empties the FIFO, not one later.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_IDLE;
      S_RUN:   if (finish) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_count_nxt == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign wr_cnt = r_wr_cnt;
  assign ovf    = r_ovf;
  assign done   = (r_state == S_DONE);

`ifdef RESHAPER_WBUF_HWM_EN
  logic [c_PW:0] r_hwm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hwm <= '0;
    end else if (init_pulse) begin
      r_hwm <= '0;
    end else if (w_count > r_hwm) begin
      r_hwm <= w_count;
    end
  end

  assign hwm = r_hwm;
`endif

endmodule
`default_nettype wire
